bar_lane_ctrl: RTL and testbench



---
 rtl/bar_lane_ctrl.sv | 150 +++++++++++++++
 tb/tb_bar_lane_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bar_lane_ctrl.sv
// bar_lane_ctrl: per-lane falling-bar controller feeding bar_sprite_src.
// Spawns a bar into a lane, drops it once per video frame, judges key
// presses against the strike window and reports hit/miss to scoring.
module bar_lane_ctrl #(
  parameter int LANE_X0      = 160,
  parameter int LANE_PITCH   = 64,
  parameter int N_LANES      = 5,
  parameter int STRIKE_Y     = 400,
  parameter int WINDOW       = 16,
  parameter int OFFSCREEN_Y  = 1024,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        spawn_valid,
  output logic        spawn_ready,
  input  logic [2:0]  spawn_lane,
  input  logic [3:0]  spawn_speed,
  input  logic        key_hit,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [6:0]  ctrl,
  output logic        hit,
  output logic        miss
);

  localparam int          CW       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [11:0] WIN_LO   = 12'(STRIKE_Y - WINDOW);
  localparam logic [11:0] WIN_HI   = 12'(STRIKE_Y + WINDOW);
  localparam logic [10:0] PARK_Y   = 11'(OFFSCREEN_Y);
  localparam logic [2:0]  MAX_LANE = 3'(N_LANES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FALL, FLASH} state_t;

  state_t        state_reg, state_next;
  logic [10:0]   x_d1_reg;
  logic [3:0]    speed_reg, speed_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [10:0]   x0_next, y0_next;
  logic [6:0]    ctrl_next;
  logic          hit_next, miss_next;

  logic          tick;
  logic [2:0]    lane_sel;
  logic [3:0]    speed_sel;
  logic [11:0]   y_ext;
  logic [11:0]   fall_sum;
  logic          in_window;

  // One pulse per frame: scan just stepped from x=0 to x=1 on line 0.
  assign tick        = (x_d1_reg == 11'd0) && (x == 11'd1) && (y == 11'd0);
  assign spawn_ready = (state_reg == IDLE) && !reset;

  // Out-of-range lanes clamp to the last lane; zero speed would stall the bar.
  assign lane_sel  = (spawn_lane > MAX_LANE) ? MAX_LANE : spawn_lane;
  assign speed_sel = (spawn_speed == 4'd0) ? 4'd1 : spawn_speed;

  // Judgement uses the current (pre-advance) origin; 12 bits avoid wrap.
  assign y_ext     = {1'b0, y0};
  assign fall_sum  = y_ext + {8'd0, speed_reg};
  assign in_window = (y_ext >= WIN_LO) && (y_ext <= WIN_HI);

  // Next-state and next-output logic for the lane FSM.
  always_comb begin
    state_next = state_reg;
    speed_next = speed_reg;
    cnt_next   = cnt_reg;
    x0_next    = x0;
    y0_next    = y0;
    ctrl_next  = ctrl;
    hit_next   = 1'b0;
    miss_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        y0_next   = PARK_Y;
        ctrl_next = 7'd0;
        if (spawn_valid && spawn_ready) begin
          state_next = FALL;
          speed_next = speed_sel;
          x0_next    = 11'(LANE_X0) + 11'(lane_sel) * 11'(LANE_PITCH);
          y0_next    = 11'd0;
          ctrl_next  = {lane_sel, 1'b0, 3'b000};
        end
      end
      FALL: begin
        // A hit takes priority over a coincident frame tick.
        if (key_hit && in_window) begin
          state_next = FLASH;
          hit_next   = 1'b1;
          ctrl_next  = ctrl | 7'h08;
          cnt_next   = '0;
        end else if (tick) begin
          if (fall_sum > WIN_HI) begin
            state_next = IDLE;
            miss_next  = 1'b1;
            y0_next    = PARK_Y;
            ctrl_next  = 7'd0;
          end else begin
            y0_next = fall_sum[10:0];
          end
        end
      end
      FLASH: begin
        if (tick) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
            y0_next    = PARK_Y;
            ctrl_next  = 7'd0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        y0_next    = PARK_Y;
        ctrl_next  = 7'd0;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset to the parked bar.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      x_d1_reg  <= 11'h7FF;
      speed_reg <= 4'd1;
      cnt_reg   <= '0;
      x0        <= 11'(LANE_X0);
      y0        <= PARK_Y;
      ctrl      <= 7'd0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_d1_reg  <= x;
      speed_reg <= speed_next;
      cnt_reg   <= cnt_next;
      x0        <= x0_next;
      y0        <= y0_next;
      ctrl      <= ctrl_next;
      hit       <= hit_next;
      miss      <= miss_next;
    end
  end

endmodule

// File: tb/tb_bar_lane_ctrl.sv
// tb_bar_lane_ctrl: directed vectors for bar_lane_ctrl with hand-computed results.
module tb_bar_lane_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [2:0]  spawn_lane;
  logic [3:0]  spawn_speed;
  logic        key_hit;
  logic [10:0] x0, y0;
  logic [6:0]  ctrl;
  logic        hit, miss;

  int n_vec = 0;
  int n_bad = 0;

  bar_lane_ctrl dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_lane(spawn_lane), .spawn_speed(spawn_speed),
    .key_hit(key_hit), .x0(x0), .y0(y0), .ctrl(ctrl),
    .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Generate one frame tick: x=0 then x=1 on line 0.
  task automatic do_tick();
    x = 11'd0; y = 11'd0;
    step();
    x = 11'd1;
    step();
    x = 11'd100; y = 11'd100;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic spawn(input logic [2:0] lane, input logic [3:0] spd);
    spawn_valid = 1'b1; spawn_lane = lane; spawn_speed = spd;
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic press();
    key_hit = 1'b1;
    step();
    key_hit = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = 11'd100; y = 11'd100;
    spawn_valid = 1'b0; spawn_lane = 3'd0; spawn_speed = 4'd0; key_hit = 1'b0;
    step(); step();
    check_val("rst_ready", spawn_ready, 0);
    check_val("rst_x0", x0, 160);
    check_val("rst_y0", y0, 1024);
    check_val("rst_ctrl", ctrl, 0);
    check_val("rst_hitmiss", {hit, miss}, 0);
    reset = 1'b0;
    step();
    check_val("post_rst_ready", spawn_ready, 1);

    // Lane 2, speed 4: fall to the strike line and hit.
    spawn(3'd2, 4'd4);
    check_val("s1_x0", x0, 288);
    check_val("s1_y0", y0, 0);
    check_val("s1_ctrl", ctrl, 7'h20);
    check_val("s1_ready", spawn_ready, 0);
    do_ticks(100);
    check_val("s1_y0_100", y0, 400);
    press();
    check_val("s1_hit", hit, 1);
    check_val("s1_ctrl_auto", ctrl, 7'h28);
    step();
    check_val("s1_hit_drop", hit, 0);
    press();
    check_val("s1_flash_key_ign", {hit, miss}, 0);
    do_ticks(7);
    check_val("s1_flash_y0", y0, 400);
    check_val("s1_flash_ctrl", ctrl, 7'h28);
    do_tick();
    check_val("s1_park_y0", y0, 1024);
    check_val("s1_park_ctrl", ctrl, 0);
    check_val("s1_park_ready", spawn_ready, 1);

    // Lane 0, speed 4, no key: miss just past the window.
    spawn(3'd0, 4'd4);
    check_val("s2_x0", x0, 160);
    do_ticks(104);
    check_val("s2_y0_416", y0, 416);
    check_val("s2_no_miss_yet", miss, 0);
    do_tick();
    check_val("s2_miss", miss, 1);
    check_val("s2_miss_hit", hit, 0);
    check_val("s2_park_y0", y0, 1024);
    check_val("s2_ready", spawn_ready, 1);
    step();
    check_val("s2_miss_drop", miss, 0);

    // Lane 7 clamps to lane 4, speed 0 acts as 1; early key ignored.
    spawn(3'd7, 4'd0);
    check_val("s3_x0", x0, 416);
    check_val("s3_ctrl", ctrl, 7'h40);
    do_tick();
    check_val("s3_y0_1", y0, 1);
    do_ticks(99);
    check_val("s3_y0_100", y0, 100);
    press();
    check_val("s3_early_key", {hit, miss}, 0);
    check_val("s3_y0_hold", y0, 100);
    do_tick();
    check_val("s3_y0_101", y0, 101);
    do_ticks(99);
    check_val("s3_y0_200", y0, 200);

    // Reset mid-fall; released with x==1,y==0 present.
    reset = 1'b1; x = 11'd0; y = 11'd0;
    step();
    check_val("s4_rst_y0", y0, 1024);
    check_val("s4_rst_ctrl", ctrl, 0);
    check_val("s4_rst_x0", x0, 160);
    check_val("s4_rst_hitmiss", {hit, miss}, 0);
    check_val("s4_rst_ready", spawn_ready, 0);
    step();
    reset = 1'b0; x = 11'd1; y = 11'd0;
    spawn_valid = 1'b1; spawn_lane = 3'd1; spawn_speed = 4'd4;
    step();
    spawn_valid = 1'b0;
    check_val("s4_spawn_y0", y0, 0);
    step();
    x = 11'd100; y = 11'd100;
    check_val("s4_no_tick_y0", y0, 0);

    // Key coincident with tick at y0=416: hit wins, y0 frozen.
    do_ticks(104);
    check_val("s5_y0_416", y0, 416);
    x = 11'd0; y = 11'd0;
    step();
    x = 11'd1; key_hit = 1'b1;
    step();
    key_hit = 1'b0; x = 11'd100; y = 11'd100;
    check_val("s5_hit", hit, 1);
    check_val("s5_no_miss", miss, 0);
    check_val("s5_y0", y0, 416);
    check_val("s5_ctrl", ctrl, 7'h18);
    do_ticks(8);
    check_val("s5_done_ready", spawn_ready, 1);

    // Lower window edge: 380 is outside, 384 is inside.
    spawn(3'd3, 4'd4);
    check_val("s6_x0", x0, 352);
    do_ticks(95);
    check_val("s6_y0_380", y0, 380);
    press();
    check_val("s6_key_380", hit, 0);
    do_tick();
    press();
    check_val("s6_key_384", hit, 1);
    check_val("s6_y0", y0, 384);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
